// File: rtl/cmp_arbiter_pkg.sv
// Shared types and constants for the two-port set-less-than comparator arbiter.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;

endpackage

// File: rtl/cmp_arbiter_slt32.sv
// Shared 32-bit set-less-than comparator: y = {31'b0, sign of (a - b) mod 2^32}.
module sub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff
);
    assign diff = a - b;
endmodule

module slt32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] diff;
    logic        unused_low;

    sub32 u_sub (
        .a    (a),
        .b    (b),
        .diff (diff)
    );

    // Raw sign of the wrapped difference; no overflow correction.
    assign y          = {31'b0, diff[31]};
    assign unused_low = ^diff[30:0];
endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter and sequencer sharing one slt32 between two requesters.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [DATA_W-1:0]        req_a0,
    input  logic [DATA_W-1:0]        req_b0,
    input  logic [DATA_W-1:0]        req_a1,
    input  logic [DATA_W-1:0]        req_b1,
    input  logic [TAG_W-1:0]         req_tag0,
    input  logic [TAG_W-1:0]         req_tag1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [1:0]               dbg_state
);

    state_t              state;
    logic                last_grant;
    logic                grant;
    logic                accept;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [TAG_W-1:0]    op_tag;
    logic                op_id;
    logic [DATA_W-1:0]   slt_y;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req_valid[1];
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && req_valid[grant]) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign dbg_state = state;

    slt32 u_slt (
        .a (op_a),
        .b (op_b),
        .y (slt_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_tag     <= '0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant ? req_a1 : req_a0;
                        op_b       <= grant ? req_b1 : req_b0;
                        op_tag     <= grant ? req_tag1 : req_tag0;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= slt_y;
                    rsp_id    <= op_id;
                    rsp_tag   <= op_tag;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_cmp_arbiter;
    import cmp_arb_pkg::*;

    localparam int TAG_W = 4;
    localparam int QW    = 1 + TAG_W + 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [31:0]       req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [TAG_W-1:0]  req_tag0 = '0, req_tag1 = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_data;
    logic              rsp_id;
    logic [TAG_W-1:0]  rsp_tag;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [QW-1:0] exp_q[$];

    cmp_arbiter #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_tag0  (req_tag0),
        .req_tag1  (req_tag1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Sign of the mathematically wrapped difference, from 64-bit arithmetic.
    function automatic logic [31:0] ref_slt(input logic [31:0] a, input logic [31:0] b);
        longint unsigned d;
        d = ({32'b0, a} + 64'h1_0000_0000 - {32'b0, b}) % 64'h1_0000_0000;
        return (d >= 64'h8000_0000) ? 32'd1 : 32'd0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_one(input bit idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, output logic [31:0] d,
                           output logic id, output logic [TAG_W-1:0] t, output bit ok);
        bit acc;
        ok = 0; acc = 0; d = '0; id = 0; t = '0;
        @(negedge clk);
        if (idx) begin req_a1 = a; req_b1 = b; req_tag1 = tag; req_valid = 2'b10; end
        else     begin req_a0 = a; req_b0 = b; req_tag0 = tag; req_valid = 2'b01; end
        rsp_ready = 1'b1;
        for (int w = 0; w < 10; w++) begin
            #1;
            if (req_ready[idx]) begin acc = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        for (int w = 0; w < 10; w++) begin
            #1;
            if (rsp_valid) begin
                d = rsp_data; id = rsp_id; t = rsp_tag; ok = acc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_tag !== '0) begin
            errors++; $display("FAIL reset_rsp_fields data=%h id=%b tag=%h exp=0", rsp_data, rsp_id, rsp_tag);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd9; req_tag0 = 4'd3; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || dbg_state !== EXEC) begin
            errors++; $display("FAIL single_cycle1 rsp_valid=%b state=%0d exp valid=0 state=%0d", rsp_valid, dbg_state, EXEC);
        end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin
            errors++; $display("FAIL single_rsp valid=%b data=%h id=%b tag=%h exp 1/00000001/0/3", rsp_valid, rsp_data, rsp_id, rsp_tag);
        end
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
            errors++; $display("FAIL single_back_idle rsp_valid=%b req_ready=%b exp 0/01", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0) begin
            errors++; $display("FAIL single_equal valid=%b data=%h exp 1/00000000", rsp_valid, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [31:0] d, a, b;
        logic id;
        logic [TAG_W-1:0] t;
        bit ok;
        run_one(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd5, d, id, t, ok);
        checks++; if (!ok || d !== 32'h1 || id !== 1'b1 || t !== 4'd5) begin
            errors++; $display("FAIL arith_overflow ok=%0d data=%h id=%b tag=%h exp 00000001/1/5", ok, d, id, t);
        end
        run_one(1'b0, 32'h8000_0000, 32'h1, 4'd6, d, id, t, ok);
        checks++; if (!ok || d !== 32'h0 || id !== 1'b0 || t !== 4'd6) begin
            errors++; $display("FAIL arith_wrap ok=%0d data=%h id=%b tag=%h exp 00000000/0/6", ok, d, id, t);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            run_one(i[0], a, b, 4'(i), d, id, t, ok);
            checks++; if (!ok || d !== ref_slt(a, b) || id !== i[0]) begin
                errors++; $display("FAIL arith_rand a=%h b=%h ok=%0d data=%h id=%b exp %h/%b", a, b, ok, d, id, ref_slt(a, b), i[0]);
            end
        end
    endtask

    task automatic test_contention();
        int k, last_acc;
        logic id_q[$];
        logic exp_id;
        k = 0; last_acc = 0;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11; rsp_ready = 1'b1;
        req_a0 = 32'd3; req_b0 = 32'd7; req_tag0 = 4'd1;
        req_a1 = 32'd7; req_b1 = 32'd3; req_tag1 = 4'd2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (req_ready != 2'b00) begin
                exp_id = k[0];
                checks++; if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_grant k=%0d got=%b exp_id=%b", k, req_ready, exp_id);
                end
                if (k > 0) begin
                    checks++; if (cyc - last_acc != 3) begin
                        errors++; $display("FAIL contention_spacing got=%0d exp=3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                id_q.push_back(exp_id);
                k++;
            end
            if (rsp_valid && id_q.size() > 0) begin
                exp_id = id_q.pop_front();
                checks++; if (rsp_id !== exp_id || rsp_data !== (exp_id ? 32'd0 : 32'd1) || rsp_tag !== (exp_id ? 4'd2 : 4'd1)) begin
                    errors++; $display("FAIL contention_rsp id=%b data=%h tag=%h exp_id=%b", rsp_id, rsp_data, rsp_tag, exp_id);
                end
            end
        end
        checks++; if (k != 4 || id_q.size() != 0) begin
            errors++; $display("FAIL contention_count grants=%0d pending=%0d exp 4/0", k, id_q.size());
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 0;
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd0; req_tag0 = 4'd9; rsp_ready = 1'b0;
        req_a1 = 32'd0; req_b1 = 32'd5; req_tag1 = 4'd4;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b11;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_timeout got=none exp=rsp_valid"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_id !== 1'b0 || rsp_tag !== 4'd9 || req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_hold i=%0d valid=%b data=%h id=%b tag=%h ready=%b exp 1/00000001/0/9/00",
                                   i, rsp_valid, rsp_data, rsp_id, rsp_tag, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin
            errors++; $display("FAIL bp_handshake valid=%b ready=%b exp 1/00", rsp_valid, req_ready);
        end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_resume valid=%b ready=%b exp 0/10", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd1 || rsp_tag !== 4'd4) begin
            errors++; $display("FAIL bp_next valid=%b id=%b data=%h tag=%h exp 1/1/00000001/4", rsp_valid, rsp_id, rsp_data, rsp_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 32'd1; req_b1 = 32'd2; req_tag1 = 4'd7; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL midop_accept got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_tag !== '0) begin
            errors++; $display("FAIL midop_reset valid=%b ready=%b data=%h id=%b tag=%h exp all 0",
                               rsp_valid, req_ready, rsp_data, rsp_id, rsp_tag);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_stale i=%0d valid=%b exp=0", i, rsp_valid); end
            @(negedge clk);
        end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midop_first_tie got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit pend[2];
        logic [31:0] pa[2], pb[2];
        logic [TAG_W-1:0] pt[2];
        bit busy, m_last, g;
        int due;
        logic [1:0] exp_ready;
        logic [QW-1:0] item;
        busy = 0; m_last = 1; due = 0; g = 0;
        pend[0] = 0; pend[1] = 0;
        exp_q.delete();
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    case ($urandom_range(0, 3))
                        0: begin pa[i] = 32'h8000_0000; pb[i] = $urandom_range(0, 3); end
                        1: begin pa[i] = 32'h7FFF_FFFF; pb[i] = 32'hFFFF_FFFF - $urandom_range(0, 3); end
                        default: begin pa[i] = $urandom; pb[i] = $urandom; end
                    endcase
                    pt[i] = TAG_W'($urandom);
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 0;
                end
            end
            req_valid = {pend[1], pend[0]};
            req_a0 = pa[0]; req_b0 = pb[0]; req_tag0 = pt[0];
            req_a1 = pa[1]; req_b1 = pb[1]; req_tag1 = pt[1];
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = 2'b00;
            if (!busy && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? !m_last : req_valid[1];
                exp_ready[g] = 1'b1;
            end
            checks++; if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, req_ready, exp_ready);
            end
            checks++; if (rsp_valid !== (busy && cyc >= due)) begin
                errors++; $display("FAIL rand_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, busy && cyc >= due);
            end
            if (busy && cyc >= due) begin
                checks++; if ({rsp_id, rsp_tag, rsp_data} !== exp_q[0]) begin
                    errors++; $display("FAIL rand_rsp n=%0d got=%h exp=%h", n, {rsp_id, rsp_tag, rsp_data}, exp_q[0]);
                end
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    busy = 0;
                end
            end
            if (exp_ready != 2'b00) begin
                item = {g, pt[g], ref_slt(pa[g], pb[g])};
                exp_q.push_back(item);
                busy = 1;
                due = cyc + 2;
                m_last = g;
                pend[g] = 0;
            end
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int w = 0; w < 6; w++) begin
            #1;
            if (rsp_valid && exp_q.size() > 0) begin
                checks++; if ({rsp_id, rsp_tag, rsp_data} !== exp_q[0]) begin
                    errors++; $display("FAIL rand_drain got=%h exp=%h", {rsp_id, rsp_tag, rsp_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rand_leftover pending=%0d rsp_valid=%b exp 0/0", exp_q.size(), rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
